// File: rtl/switch_debouncer.sv
// switch_debouncer: two-channel synchronizer + debouncer for raw board
// switches feeding the logic-gate blocks.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   sw_a, sw_b   raw, asynchronous, bouncy switch inputs
//   a, b         debounced, synchronous levels
//   changed      one-cycle pulse, the cycle after a and/or b updates
//   a_rise/a_fall/b_rise/b_fall  (only with SWITCH_DEBOUNCER_EDGE_EN)
//                one-cycle edge pulses, coincident with changed
//
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN
// DEBOUNCE_CYCLES: 4 for simulation, ~500000 on board at 50 MHz.

// Per-channel lane: 2-flop synchronizer and debounce counter.
module switch_debouncer_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic sw,
  output logic stable,
  output logic upd
);
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      upd    <= 1'b0;
    end else begin
      s1  <= sw;
      s2  <= s1;
      upd <= 1'b0;
      // Any cycle back at the stable level restarts the qualification window,
      // so cnt is bounded by DEBOUNCE_CYCLES-1 and cannot wrap.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
        upd    <= 1'b1;  // high in the same cycle the new level appears
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
`endif
  output logic changed
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] sw_vec;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] upd;

  assign sw_vec = {sw_b, sw_a};

  switch_debouncer_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan [NUM_CH-1:0] (
    .clock  (clock),
    .reset  (reset),
    .sw     (sw_vec),
    .stable (stable),
    .upd    (upd)
  );

  assign a = stable[0];
  assign b = stable[1];

  // upd is already registered, so this pulse lands one cycle after the
  // level change; a simultaneous update on both lanes merges into one pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |upd;
  end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  // stable already holds the new level when upd is high, so it gives direction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rise <= 1'b0;
      a_fall <= 1'b0;
      b_rise <= 1'b0;
      b_fall <= 1'b0;
    end else begin
      a_rise <= upd[0] &  stable[0];
      a_fall <= upd[0] & ~stable[0];
      b_rise <= upd[1] &  stable[1];
      b_fall <= upd[1] & ~stable[1];
    end
  end
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic rst, sw_a, sw_b;
  logic a, b, changed;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic a_rise, a_fall, b_rise, b_fall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic ch;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clock   (clk),
    .reset   (rst),
    .sw_a    (sw_a),
    .sw_b    (sw_b),
    .a       (a),
    .b       (b),
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    .a_rise  (a_rise),
    .a_fall  (a_fall),
    .b_rise  (b_rise),
    .b_fall  (b_fall),
`endif
    .changed (changed)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sw_a = 1'b0; sw_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    @(negedge clk);
    rst = 1'b1; sw_a = 1'b1; sw_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q.push_back(exp_t'(3'b000));
      @(posedge clk); #1;
      e = q.pop_front(); got = {a, b, changed};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b required %b", i, got, e);
      end
    end
    // Release with switches held high: both lanes settle to 1.
    @(negedge clk); rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    q.push_back(exp_t'(3'b110));
    e = q.pop_front(); got = {a, b, changed};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_prep: got %b required %b", got, e);
    end
    // Asynchronous assertion mid-cycle must clear before any edge.
    #2 rst = 1'b1;
    q.push_back(exp_t'(3'b000));
    #1;
    e = q.pop_front(); got = {a, b, changed};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_async: got %b required %b", got, e);
    end
    @(negedge clk); rst = 1'b0; sw_a = 1'b0; sw_b = 1'b0;
  endtask

  task automatic test_clean_step();
    exp_t e, got;
    do_reset();
    repeat (4) @(negedge clk);
    sw_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q.push_back({(i >= 5), 1'b0, (i == 6)});
      @(posedge clk); #1;
      e = q.pop_front(); got = {a, b, changed};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL clean_step edge%0d: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e, got;
    logic pat [0:11];
    do_reset();
    repeat (4) @(negedge clk);
    // toggle 1,0,1,0 then settle low; later a 3-cycle high pulse.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      sw_b = (i < 12) ? pat[i] : 1'b0;
      q.push_back(exp_t'(3'b000));
      @(posedge clk); #1;
      e = q.pop_front(); got = {a, b, changed};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL bounce cyc%0d: got %b required %b", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e, got;
    int pulses = 0;
    do_reset();
    repeat (4) @(negedge clk);
    sw_a = 1'b1; sw_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q.push_back({(i >= 5), (i >= 5), (i == 6)});
      @(posedge clk); #1;
      pulses += int'(changed);
      e = q.pop_front(); got = {a, b, changed};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL simultaneous edge%0d: got %b required %b", i, got, e);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL simul_pulses: got %0d required 1", pulses);
    end
    n_checks++;
    if ((a & b) !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_and: got %b required 1", a & b);
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e, got;
    do_reset();
    repeat (4) @(negedge clk);
    sw_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q.push_back({(i >= 5), 1'b0, (i == 6)});
      @(posedge clk); #1;
      e = q.pop_front(); got = {a, b, changed};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_midcount edge%0d: got %b required %b", i, got, e);
      end
    end
  endtask

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  task automatic test_edge_detect();
    logic [6:0] eq[$];
    logic [6:0] e7, g7;
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sw_a = (i < 10);
      // {a, b, changed, a_rise, a_fall, b_rise, b_fall}
      eq.push_back({(i >= 5 && i < 15), 1'b0, (i == 6 || i == 16),
                    (i == 6), (i == 16), 1'b0, 1'b0});
      @(posedge clk); #1;
      e7 = eq.pop_front();
      g7 = {a, b, changed, a_rise, a_fall, b_rise, b_fall};
      n_checks++;
      if (g7 !== e7) begin
        n_fail++;
        $display("FAIL edge_detect cyc%0d: got %b required %b", i, g7, e7);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; sw_a = 1'b0; sw_b = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    test_edge_detect();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
